dataoutput_collect: RTL and testbench

//  Output-side counterpart of the input buffer/setup path: captures the skewed per-lane

---
 rtl/dataoutput_collect_pkg.sv | 14 +
 rtl/dataoutput_collect_buff_output.sv | 28 ++
 rtl/dataoutput_collect.sv | 133 +++++++++++++
 tb/tb_dataoutput_collect.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dataoutput_collect_pkg.sv
// dataoutput_pkg: shared types and default geometry for the result collector.
//   collect_state_t : collector FSM states
//   DEPTH_AW/LANE_AW: depth / lane field widths of the flat read address
//                     for the default geometry (1024 x 25 lanes)
package dataoutput_pkg;
  localparam int SRAM_DEPTH_DEF = 1024;
  localparam int BAND_WIDTH_DEF = 25;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int BURST_W        = 11;
  localparam int DEPTH_AW       = $clog2(SRAM_DEPTH_DEF);
  localparam int LANE_AW        = $clog2(BAND_WIDTH_DEF);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} collect_state_t;
endpackage

// File: rtl/dataoutput_collect_buff_output.sv
// buff_output: one lane's result RAM, simple dual port.
//   clk/rst          : clock, async active-high reset (read register only)
//   we/waddr/wdata   : write port
//   re/raddr/rdata   : read port, 1-cycle latency; rdata holds when re=0
// The array itself is not reset.
module buff_output #(
  parameter int DEPTH = 1024,
  parameter int DW    = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk or posedge rst)
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/dataoutput_collect.sv
// dataoutput_collect: de-skews the per-lane systolic-array result stream into
// BAND_WIDTH lane RAMs and exposes one flat {lane, depth} read port.
//   clk, rst                   : clock, async active-high reset
//   BURST_SIZE, start_i        : arm a collection of BURST_SIZE words per lane
//   sa_valid_i, sa_data_i      : per-lane result stream (lanes may be skewed)
//   collect_busy_o, done_o     : state decodes (COLLECT / DONE)
//   overflow_o                 : sticky, a word arrived on an already-full lane
//   clear_i                    : DONE -> IDLE, clears overflow_o
//   rd_en_i, rd_addr_i         : read request, served in DONE only
//   rd_data_o, rd_valid_o      : read response, 1-cycle latency
module dataoutput_collect
  import dataoutput_pkg::*;
#(
  parameter int SRAM_DEPTH = SRAM_DEPTH_DEF,
  parameter int BAND_WIDTH = BAND_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int DAW = $clog2(SRAM_DEPTH),
  localparam int LAW = $clog2(BAND_WIDTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [BURST_W-1:0]                   BURST_SIZE,
  input  logic                                 start_i,
  input  logic [BAND_WIDTH-1:0]                sa_valid_i,
  input  logic [BAND_WIDTH-1:0][DATA_WIDTH-1:0] sa_data_i,
  output logic                                 collect_busy_o,
  output logic                                 done_o,
  output logic                                 overflow_o,
  input  logic                                 clear_i,
  input  logic                                 rd_en_i,
  input  logic [LAW+DAW-1:0]                   rd_addr_i,
  output logic [DATA_WIDTH-1:0]                rd_data_o,
  output logic                                 rd_valid_o
);
  collect_state_t state, nxt;

  logic [BURST_W-1:0]                    burst_q;
  logic [BAND_WIDTH-1:0][DAW:0]          wptr;
  logic [DAW:0]                          limit;
  logic [BAND_WIDTH-1:0]                 full, we, re;
  logic                                  all_full, ovf_hit, rd_fire, oob, oob_q;
  logic [LAW-1:0]                        rd_lane, lane_q;
  logic [DAW-1:0]                        rd_depth;
  logic [BAND_WIDTH-1:0][DATA_WIDTH-1:0] ram_q;

  // A lane's capacity is the burst, capped at the RAM depth; words beyond
  // the cap are treated as overflow rather than wrapping.
  always_comb
    limit = (32'(burst_q) > 32'(SRAM_DEPTH)) ? (DAW+1)'(SRAM_DEPTH) : (DAW+1)'(burst_q);

  assign rd_lane  = rd_addr_i[LAW+DAW-1:DAW];
  assign rd_depth = rd_addr_i[DAW-1:0];
  assign rd_fire  = rd_en_i && (state == DONE);
  assign oob      = 32'(rd_lane) >= 32'(BAND_WIDTH);

  always_comb begin
    full = '0;
    we   = '0;
    re   = '0;
    for (int i = 0; i < BAND_WIDTH; i++) begin
      full[i] = wptr[i] >= limit;
      we[i]   = (state == COLLECT) && sa_valid_i[i] && !full[i];
      re[i]   = rd_fire && !oob && (rd_lane == LAW'(i));
    end
    all_full = &full;
    ovf_hit  = (state == COLLECT) && |(sa_valid_i & full);
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start_i) nxt = (BURST_SIZE == '0) ? DONE : COLLECT;
      COLLECT: if (all_full) nxt = DONE;
      DONE:    if (clear_i) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      burst_q    <= '0;
      wptr       <= '0;
      overflow_o <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start_i) begin
        burst_q <= BURST_SIZE;
        wptr    <= '0;
      end else begin
        for (int i = 0; i < BAND_WIDTH; i++)
          if (we[i]) wptr[i] <= wptr[i] + (DAW+1)'(1);
      end
      if (ovf_hit)                      overflow_o <= 1'b1;
      else if (state == DONE && clear_i) overflow_o <= 1'b0;
    end
  end

  for (genvar g = 0; g < BAND_WIDTH; g++) begin : g_lane
    buff_output #(.DEPTH(SRAM_DEPTH), .DW(DATA_WIDTH), .AW(DAW)) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (we[g]),
      .waddr (wptr[g][DAW-1:0]),
      .wdata (sa_data_i[g]),
      .re    (re[g]),
      .raddr (rd_depth),
      .rdata (ram_q[g])
    );
  end

  // Lane select and out-of-range flag are captured with the read so the
  // output mux sees only registers; an un-served cycle leaves all of them
  // (and the lane RAM read register) untouched, so rd_data_o holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_o <= 1'b0;
      lane_q     <= '0;
      oob_q      <= 1'b0;
    end else begin
      rd_valid_o <= rd_fire;
      if (rd_fire) begin
        lane_q <= rd_lane;
        oob_q  <= oob;
      end
    end
  end

  always_comb rd_data_o = oob_q ? '0 : ram_q[lane_q];

  assign collect_busy_o = (state == COLLECT);
  assign done_o         = (state == DONE);
endmodule

// File: tb/tb_dataoutput_collect.sv
module tb_dataoutput_collect;
  import dataoutput_pkg::*;
  localparam int BW = 25, DW = 16, AW = DEPTH_AW + LANE_AW;

  logic                   clk = 1'b0, rst;
  logic [BURST_W-1:0]     burst;
  logic                   start, clear, rd_en;
  logic [BW-1:0]          sa_valid;
  logic [BW-1:0][DW-1:0]  sa_data;
  logic [AW-1:0]          rd_addr;
  logic                   busy, done, ovf, rd_valid;
  logic [DW-1:0]          rd_data;

  dataoutput_collect dut (
    .clk(clk), .rst(rst), .BURST_SIZE(burst), .start_i(start),
    .sa_valid_i(sa_valid), .sa_data_i(sa_data),
    .collect_busy_o(busy), .done_o(done), .overflow_o(ovf),
    .clear_i(clear), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Read monitor: every rd_valid_o must match the oldest expected word.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid_o=1 data 0x%0h, required no read", rd_data);
      end else begin
        chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int lane, input int d, input logic [DW-1:0] e);
    rd_en   = 1'b1;
    rd_addr = AW'((lane << DEPTH_AW) | d);
    exp_q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic arm(input int b);
    burst = BURST_W'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    chk("done_wait", 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; burst = '0; start = 0; clear = 0; rd_en = 0;
    sa_valid = '0; sa_data = '0; rd_addr = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    rst = 1'b0;
    tick();

    // Burst 4, lane i skewed +i cycles, data = lane*16 + k.
    arm(4);
    chk("A_busy", 32'(busy), 1);
    for (int c = 0; c < 28; c++) begin
      for (int i = 0; i < BW; i++) begin
        sa_valid[i] = (c >= i) && (c < i + 4);
        sa_data[i]  = sa_valid[i] ? DW'(i * 16 + c - i) : 16'hdead;
      end
      tick();
      if (c == 10) chk("A_busy_mid", 32'(busy), 1);
    end
    sa_valid = '0;
    // Lane 24's last word was just written; DONE follows one edge later,
    // i.e. 29 cycles after lane 0's first word was presented.
    chk("A_not_done_yet", 32'(done), 0);
    tick();
    chk("A_done", 32'(done), 1);
    chk("A_busy_off", 32'(busy), 0);
    chk("A_no_ovf", 32'(ovf), 0);
    rd(3, 2, 16'h0032);
    rd(24, 3, 16'h0183);
    rd(0, 0, 16'h0000);
    rd(30, 0, 16'h0000);
    rd(9, 1, 16'h0091);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("A_cleared", 32'(done), 0);

    // Burst 0 goes straight to DONE.
    arm(0);
    chk("B_busy", 32'(busy), 0);
    chk("B_done", 32'(done), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("B_cleared", 32'(done), 0);

    // Burst 2; lane 5 sends 3 words early, others 2 words two cycles later.
    arm(2);
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < BW; i++) begin
        if (i == 5) begin
          sa_valid[i] = (c < 3);
          sa_data[i]  = DW'(16'h0501 + c);
        end else begin
          sa_valid[i] = (c >= 2);
          sa_data[i]  = DW'(i * 256 + c - 2);
        end
      end
      tick();
      if (c == 2) chk("C_ovf_set", 32'(ovf), 1);
    end
    sa_valid = '0;
    chk("C_not_done_yet", 32'(done), 0);
    tick();
    chk("C_done", 32'(done), 1);
    chk("C_ovf_sticky", 32'(ovf), 1);
    rd(5, 0, 16'h0501);
    rd(5, 1, 16'h0502);
    rd(7, 1, 16'h0701);
    // clear together with a read: the read is still served
    clear = 1'b1;
    rd(24, 1, 16'h1801);
    clear = 1'b0;
    chk("C_idle_done", 32'(done), 0);
    chk("C_idle_busy", 32'(busy), 0);
    chk("C_ovf_cleared", 32'(ovf), 0);

    // Read during COLLECT is ignored and rd_data_o holds its last value.
    arm(4);
    rd_en = 1'b1;
    rd_addr = AW'((3 << DEPTH_AW) | 2);
    tick();
    rd_en = 1'b0;
    chk("D_rd_valid_collect", 32'(rd_valid), 0);
    chk("D_rd_data_hold", 32'(rd_data), 32'h1801);
    for (int i = 0; i < BW; i++) begin
      sa_valid[i] = 1'b1;
      sa_data[i]  = DW'(16'h0600 + i);
    end
    tick();
    sa_valid = '0;
    // Reset mid-collection: outputs drop without waiting for a clock edge.
    rst = 1'b1;
    #1;
    chk("D_rst_busy", 32'(busy), 0);
    chk("D_rst_done", 32'(done), 0);
    chk("D_rst_ovf", 32'(ovf), 0);
    chk("D_rst_rd_data", 32'(rd_data), 0);
    #3;
    rst = 1'b0;
    tick();
    chk("D_idle_after_rst", 32'(done), 0);
    arm(1);
    for (int i = 0; i < BW; i++) begin
      sa_valid[i] = 1'b1;
      sa_data[i]  = DW'(16'h0700 + i);
    end
    tick();
    sa_valid = '0;
    wait_done(10);
    rd(12, 0, 16'h070C);
    rd(0, 0, 16'h0700);
    tick();
    tick();
    chk("rd_pending", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
